// File: rtl/csr_access_ctrl_if.sv
// CSR access controller bus bundle: WBU request/response, trap request,
// CSR file read/write ports and the IFU redirect channel.
// master = surrounding pipeline / CSR file side, slave = csr_access_ctrl.
interface csr_access_ctrl_if;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;

    // WBU CSR instruction channel
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [OP_W-1:0]   wb_op;
    logic [DATA_W-1:0] wb_src;
    logic              wb_done;
    logic [DATA_W-1:0] wb_rd_data;

    // trap unit channel
    logic              trap_valid;
    logic              trap_ready;
    logic              trap_kind;
    logic [DATA_W-1:0] trap_pc;

    // CSR file ports
    logic [ADDR_W-1:0] csr_raddr;
    logic [DATA_W-1:0] csr_rdata;
    logic [ADDR_W-1:0] csr_waddr;
    logic [DATA_W-1:0] csr_wdata;
    logic              csr_wen;

    // IFU redirect channel
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              redirect_ready;

    modport master (
        output wb_valid, wb_addr, wb_op, wb_src,
        output trap_valid, trap_kind, trap_pc,
        output csr_rdata, redirect_ready,
        input  wb_ready, wb_done, wb_rd_data, trap_ready,
        input  csr_raddr, csr_waddr, csr_wdata, csr_wen,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  wb_valid, wb_addr, wb_op, wb_src,
        input  trap_valid, trap_kind, trap_pc,
        input  csr_rdata, redirect_ready,
        output wb_ready, wb_done, wb_rd_data, trap_ready,
        output csr_raddr, csr_waddr, csr_wdata, csr_wen,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences all machine-mode CSR file accesses, arbitrating
// between WBU read-modify-write instructions and trap-unit ecall/mret
// requests, and issues the PC redirect after a trap or return.
// Optional build macro: CSR_MSTATUS_UPDATE_EN adds the mstatus
// MIE/MPIE/MPP update (MS_RD/MS_WR) to the ecall and mret sequences.
module csr_access_ctrl #(
    parameter bit          TRAP_PRIO   = 1'b1,
    parameter logic [31:0] CAUSE_ECALL = 32'h0000000b
) (
    input  logic                clk,
    input  logic                rst,
    csr_access_ctrl_if.slave    bus,
    output logic                busy
);
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_RO = 2'b00;
    localparam logic [OP_W-1:0] OP_RW = 2'b01;
    localparam logic [OP_W-1:0] OP_RS = 2'b10;
    localparam logic [OP_W-1:0] OP_RC = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [ADDR_W-1:0] ADDR_MTVEC     = 12'h305;
    localparam logic [ADDR_W-1:0] ADDR_MEPC      = 12'h341;
    localparam logic [ADDR_W-1:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [ADDR_W-1:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [ADDR_W-1:0] ADDR_MARCHID   = 12'hF12;

    localparam logic [DATA_W-1:0] VEC_MASK = 32'hFFFF_FFFC;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        WR,
        TR_EPC,
        TR_CAUSE,
        TR_VEC,
        REDIR,
        MS_RD,
        MS_WR
    } state_t;

    state_t            state;

    // saved request
    logic [ADDR_W-1:0] s_addr;
    logic [OP_W-1:0]   s_op;
    logic [DATA_W-1:0] s_src;
    logic              s_kind;

    // registered outputs
    logic [ADDR_W-1:0] csr_raddr_q;
    logic [ADDR_W-1:0] csr_waddr_q;
    logic [DATA_W-1:0] csr_wdata_q;
    logic              csr_wen_q;
    logic              wb_done_q;
    logic [DATA_W-1:0] wb_rd_data_q;
    logic              redirect_valid_q;
    logic [DATA_W-1:0] redirect_pc_q;

    logic              idle_c;
    logic              wb_acc_c;
    logic              tr_acc_c;
    logic [DATA_W-1:0] rmw_c;
    logic              rmw_wen_c;

    // Ready is only offered in IDLE; the priority rule keeps the two
    // handshakes mutually exclusive.
    assign idle_c         = rst && (state == IDLE);
    assign bus.wb_ready   = idle_c && !(TRAP_PRIO && bus.trap_valid);
    assign bus.trap_ready = idle_c && !(!TRAP_PRIO && bus.wb_valid);
    assign wb_acc_c       = bus.wb_valid && bus.wb_ready;
    assign tr_acc_c       = bus.trap_valid && bus.trap_ready;

    assign bus.csr_raddr      = csr_raddr_q;
    assign bus.csr_waddr      = csr_waddr_q;
    assign bus.csr_wdata      = csr_wdata_q;
    assign bus.csr_wen        = csr_wen_q;
    assign bus.wb_done        = wb_done_q;
    assign bus.wb_rd_data     = wb_rd_data_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

    // New CSR value and write qualification for the WBU read-modify-write.
    always_comb begin
        rmw_c     = bus.csr_rdata;
        rmw_wen_c = 1'b1;
        case (s_op)
            OP_RW:   rmw_c = s_src;
            OP_RS:   rmw_c = bus.csr_rdata | s_src;
            OP_RC:   rmw_c = bus.csr_rdata & ~s_src;
            default: rmw_c = bus.csr_rdata;
        endcase
        if (s_op == OP_RO)
            rmw_wen_c = 1'b0;
        if (s_op[1] && (s_src == '0))
            rmw_wen_c = 1'b0;
        if ((s_addr == ADDR_MVENDORID) || (s_addr == ADDR_MARCHID))
            rmw_wen_c = 1'b0;
    end

`ifdef CSR_MSTATUS_UPDATE_EN
    logic [DATA_W-1:0] ms_new_c;

    // mstatus interrupt-stack update: ecall pushes MIE, mret pops it.
    always_comb begin
        ms_new_c        = bus.csr_rdata;
        ms_new_c[12:11] = 2'b11;
        if (!s_kind) begin
            ms_new_c[7] = bus.csr_rdata[3];
            ms_new_c[3] = 1'b0;
        end else begin
            ms_new_c[3] = bus.csr_rdata[7];
            ms_new_c[7] = 1'b1;
        end
    end
`endif

    // Sequencer: state plus outputs registered for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            s_addr           <= '0;
            s_op             <= '0;
            s_src            <= '0;
            s_kind           <= 1'b0;
            csr_raddr_q      <= '0;
            csr_waddr_q      <= '0;
            csr_wdata_q      <= '0;
            csr_wen_q        <= 1'b0;
            wb_done_q        <= 1'b0;
            wb_rd_data_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            csr_raddr_q  <= '0;
            csr_waddr_q  <= '0;
            csr_wdata_q  <= '0;
            csr_wen_q    <= 1'b0;
            wb_done_q    <= 1'b0;
            wb_rd_data_q <= '0;
            case (state)
                IDLE: begin
                    if (wb_acc_c) begin
                        s_addr      <= bus.wb_addr;
                        s_op        <= bus.wb_op;
                        s_src       <= bus.wb_src;
                        csr_raddr_q <= bus.wb_addr;
                        busy        <= 1'b1;
                        state       <= RD;
                    end else if (tr_acc_c) begin
                        s_kind <= bus.trap_kind;
                        busy   <= 1'b1;
                        if (!bus.trap_kind) begin
                            csr_wen_q   <= 1'b1;
                            csr_waddr_q <= ADDR_MEPC;
                            csr_wdata_q <= bus.trap_pc;
                            state       <= TR_EPC;
                        end else begin
`ifdef CSR_MSTATUS_UPDATE_EN
                            csr_raddr_q <= ADDR_MSTATUS;
                            state       <= MS_RD;
`else
                            csr_raddr_q <= ADDR_MEPC;
                            state       <= TR_VEC;
`endif
                        end
                    end
                end
                RD: begin
                    wb_rd_data_q <= bus.csr_rdata;
                    wb_done_q    <= 1'b1;
                    csr_waddr_q  <= s_addr;
                    csr_wdata_q  <= rmw_c;
                    csr_wen_q    <= rmw_wen_c;
                    state        <= WR;
                end
                WR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                TR_EPC: begin
                    csr_wen_q   <= 1'b1;
                    csr_waddr_q <= ADDR_MCAUSE;
                    csr_wdata_q <= CAUSE_ECALL;
                    state       <= TR_CAUSE;
                end
                TR_CAUSE: begin
`ifdef CSR_MSTATUS_UPDATE_EN
                    csr_raddr_q <= ADDR_MSTATUS;
                    state       <= MS_RD;
`else
                    csr_raddr_q <= ADDR_MTVEC;
                    state       <= TR_VEC;
`endif
                end
`ifdef CSR_MSTATUS_UPDATE_EN
                MS_RD: begin
                    csr_wen_q   <= 1'b1;
                    csr_waddr_q <= ADDR_MSTATUS;
                    csr_wdata_q <= ms_new_c;
                    state       <= MS_WR;
                end
                MS_WR: begin
                    csr_raddr_q <= s_kind ? ADDR_MEPC : ADDR_MTVEC;
                    state       <= TR_VEC;
                end
`endif
                TR_VEC: begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= s_kind ? bus.csr_rdata
                                               : (bus.csr_rdata & VEC_MASK);
                    state            <= REDIR;
                end
                REDIR: begin
                    if (bus.redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        redirect_pc_q    <= '0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequences every access to the machine-mode CSR file.
- Arbitrates between two requesters:
  - WBU CSR instructions (csrrw/csrrs/csrrc read-modify-write).
  - Trap requests from the trap unit (ecall, mret).
- Drives the CSR file's single read port and single write port.
- Issues the PC redirect to the IFU after a trap or return.

Parameters:
- TRAP_PRIO, 1: 1 = trap wins a simultaneous request in IDLE; 0 = WBU wins.
- CAUSE_ECALL, 32'h0000000b: value written to mcause on ecall.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- wb_valid  in  1  WBU CSR request valid
- wb_ready  out  1  WBU request accepted when wb_valid && wb_ready
- wb_addr  in  12  CSR address
- wb_op  in  2  00 read-only, 01 RW, 10 RS, 11 RC
- wb_src  in  32  rs1 value or zimm
- wb_done  out  1  one-cycle pulse at completion of a WBU request
- wb_rd_data  out  32  old CSR value; valid when wb_done=1
- trap_valid  in  1  trap request valid
- trap_ready  out  1  trap request accepted when trap_valid && trap_ready
- trap_kind  in  1  0 ecall, 1 mret
- trap_pc  in  32  PC of the trapping instruction
- csr_raddr  out  12  CSR file read address (file reads combinationally)
- csr_rdata  in  32  CSR file read data
- csr_waddr  out  12  CSR file write address
- csr_wdata  out  32  CSR file write data
- csr_wen  out  1  CSR file write enable
- redirect_valid  out  1  redirect PC valid
- redirect_pc  out  32  target PC
- redirect_ready  in  1  IFU accepts the redirect
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; all saved request registers 0.
- States: IDLE, RD, WR, TR_EPC, TR_CAUSE, TR_VEC, REDIR.
- IDLE:
  - wb_ready = ~(TRAP_PRIO && trap_valid).
  - trap_ready = ~(!TRAP_PRIO && wb_valid).
  - At most one handshake per cycle.
  - On handshake, latch addr/op/src or kind/pc.
  - WBU accept -> RD; ecall accept -> TR_EPC; mret accept -> TR_VEC.
- All other states: wb_ready = trap_ready = 0.
- RD:
  - csr_raddr = saved addr; latch csr_rdata into old_val.
  - Next state WR.
- WR:
  - csr_waddr = saved addr.
  - csr_wdata by op: RW = src; RS = old|src; RC = old&~src.
  - csr_wen = 1 except when any of:
    - op==00;
    - op in {RS,RC} with src==0;
    - addr in {12'hF11, 12'hF12} (read-only).
  - wb_done = 1 and wb_rd_data = old_val in this cycle.
  - Next state IDLE.
  - WBU latency: accept cycle + 2 (done in 2nd cycle after accept).
- TR_EPC: csr_wen=1, csr_waddr=12'h341, csr_wdata=saved pc -> TR_CAUSE.
- TR_CAUSE: csr_wen=1, csr_waddr=12'h342, csr_wdata=CAUSE_ECALL -> TR_VEC.
- TR_VEC:
  - csr_raddr = 12'h305 (ecall) or 12'h341 (mret).
  - Latch target: ecall uses csr_rdata & ~32'h3 (direct mode); mret uses csr_rdata as is.
  - Next state REDIR.
  - The mepc write in TR_EPC is visible by this cycle.
- REDIR:
  - redirect_valid=1, redirect_pc=target.
  - Hold until redirect_ready=1, then IDLE.
  - redirect_pc stable while waiting.
- csr_wen, wb_done, redirect_valid are 0 in every state not listed above for them.
- Requests presented while busy are not accepted; requesters hold valid and payload until ready.
- Reset mid-sequence aborts it: CSR writes already issued remain; no redirect, no wb_done.
- Only 12-bit address compares; no other width conversion.

Optional Feature:
- Macro CSR_MSTATUS_UPDATE_EN.
- Defined: adds states MS_RD and MS_WR.
  - ecall path: TR_CAUSE -> MS_RD -> MS_WR -> TR_VEC. mret path: IDLE -> MS_RD -> MS_WR -> TR_VEC.
  - MS_RD latches mstatus (12'h300).
  - MS_WR writes 12'h300:
    - ecall: MPIE<=MIE, MIE<=0, MPP<=2'b11.
    - mret: MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - Other bits preserved.
- Not defined: mstatus is never touched; transitions as above.

Test Plan:
- RW: CSR file mtvec=0x0; wb_valid, addr=0x305, op=01, src=0x80000100 -> done 2 cycles after accept, wb_rd_data=0; csr_wen=1, wdata=0x80000100 in WR cycle.
- RS with src=0 on mstatus=0x1800 -> wb_rd_data=0x1800, csr_wen=0 in WR; RC src=0x8 on 0x1808 -> wdata=0x1800.
- Write to 12'hF11 op=01 -> wb_rd_data=0x79737978, csr_wen=0.
- ecall, pc=0x80000010, mtvec=0x80000103:
  - mepc<=0x80000010, mcause<=0xb on consecutive cycles.
  - redirect_pc=0x80000100.
  - Hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable.
- trap_valid and wb_valid same IDLE cycle, TRAP_PRIO=1 -> trap_ready=1, wb_ready=0; WBU accepted in first IDLE after redirect; mret then redirects to mepc=0x80000010.
- rst driven low during TR_CAUSE -> outputs 0 asynchronously; no redirect after release; next request serviced normally.
